// File: rtl/i2c_target_rx_pkg.sv
// Shared definitions for the I2C target receiver: field widths, ACK/NACK levels
// and the FSM state encoding.
package i2c_target_rx_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_ACK_WR   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL and bus SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronized value and one history flop.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle bus level so leaving reset never fakes an edge on SDA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL must be high in both samples, so an SDA edge that coincides with an
  // SCL edge is treated as data, never as START/STOP.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target endpoint: decodes address/RNW, accepts a two-byte write word or
// serves a two-byte read word, driving SDA_IN for ACK and read data.
module i2c_target_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  input  logic                  SDA_OUT,
  input  logic                  SDA_OE,
  input  logic [6:0]            I2C_ADDR,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  SDA_IN,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_STB,
  output logic                  RD_STB,
  output logic                  BUSY,
  output logic [2:0]            dbg_state
);
  import i2c_target_rx_pkg::*;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA_OE ? SDA_OUT : 1'b1),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [BYTE_W-1:0]       rx_q, rx_d;
  logic [BYTE_W-1:0]       byte0_q, byte0_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    sda_q, sda_d;
  logic                    busy_q, busy_d;
  logic                    wr_stb_d, rd_stb_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rx_q      <= '0;
      byte0_q   <= '0;
      tx_q      <= '0;
      wr_data_q <= '0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      WR_STB    <= 1'b0;
      RD_STB    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rx_q      <= rx_d;
      byte0_q   <= byte0_d;
      tx_q      <= tx_d;
      wr_data_q <= wr_data_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      WR_STB    <= wr_stb_d;
      RD_STB    <= rd_stb_d;
    end
  end

  // Bit slots begin at an SCL fall: SDA_IN only changes on falls, data is
  // sampled on rises, and cnt_q counts the rises seen in the current byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rx_d      = rx_q;
    byte0_d   = byte0_q;
    tx_d      = tx_q;
    wr_data_d = wr_data_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;

    if (stop_det) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      sda_d   = NACK;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      busy_d  = 1'b1;
      sda_d   = NACK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_d  = {rx_q[BYTE_W-2:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (rx_q[BYTE_W-1:1] == I2C_ADDR) begin
              state_d = ST_ACK_ADDR;
              sda_d   = ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            cnt_d = '0;
            idx_d = '0;
            if (rx_q[0]) begin
              tx_d     = {RD_DATA[DATA_WIDTH-2:0], 1'b0};
              sda_d    = RD_DATA[DATA_WIDTH-1];
              rd_stb_d = 1'b1;
              state_d  = ST_RD_BYTE;
            end else begin
              sda_d   = NACK;
              state_d = ST_WR_BYTE;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            rx_d  = {rx_q[BYTE_W-2:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = ST_ACK_WR;
            sda_d   = (idx_q < 2'd2) ? ACK : NACK;
            if (idx_q == 2'd0) byte0_d = rx_q;
            if (idx_q == 2'd1) begin
              wr_data_d = {byte0_q, rx_q};
              wr_stb_d  = 1'b1;
            end
            if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
          end
        end
        ST_ACK_WR: begin
          if (scl_fall) begin
            sda_d   = NACK;
            state_d = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = '0;
              sda_d   = NACK;
              state_d = ST_RD_ACK;
            end else begin
              sda_d = tx_q[DATA_WIDTH-1];
              tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          // cnt_q marks that the master's ACK was seen on this slot's rise.
          if (scl_rise) begin
            if (sda_s == NACK || idx_q != 2'd0) state_d = ST_IGNORE;
            else                                cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            cnt_d   = '0;
            idx_d   = 2'd1;
            sda_d   = tx_q[DATA_WIDTH-1];
            tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
            state_d = ST_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_IN    = sda_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = busy_q;
  assign dbg_state = state_q;

endmodule
